// File: rtl/sem_mailbox_pkg.sv
// +-----------------------------------------------------------------------+
// | sem_mailbox_pkg : default sizing for the semaphore mailbox            |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package sem_mailbox_pkg;

  localparam int SEM_DATA_WIDTH = 8;
  localparam int SEM_CH_NO      = 2;
  localparam int SEM_FIFO_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/sem_fifo_ch.sv
// +-----------------------------------------------------------------------+
// | sem_fifo_ch : one show-ahead mailbox channel with sticky error flags  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module sem_fifo_ch
  import sem_mailbox_pkg::*;
#(
  parameter  int DATA_WIDTH = SEM_DATA_WIDTH,
  parameter  int DEPTH      = SEM_FIFO_DEPTH,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_read,
  output logic                  empty,
  output logic [CNT_W-1:0]      level,
  input  logic                  flush,
  output logic                  ovf,
  output logic                  udf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  push, pop;

  // Status comes only from the registered count: no input-to-output path.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign rd_valid = ~empty;
  assign level    = count_q;
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign ovf      = ovf_q;
  assign udf      = udf_q;

  // A pop on a full channel frees the slot the push needs this same edge.
  assign push = wr_valid & (~full | rd_read) & ~flush;
  assign pop  = rd_read & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = err_clr ? 1'b0 : ovf_q;
    udf_d    = err_clr ? 1'b0 : udf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (wr_valid && full && !rd_read) ovf_d = 1'b1;
      if (rd_read && empty)             udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/sem_mailbox.sv
// +-----------------------------------------------------------------------+
// | sem_mailbox : NUM_CH independent semaphore FIFOs between CPU cores    |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module sem_mailbox
  import sem_mailbox_pkg::*;
#(
  parameter  int DATA_WIDTH = SEM_DATA_WIDTH,
  parameter  int NUM_CH     = SEM_CH_NO,
  parameter  int DEPTH      = SEM_FIFO_DEPTH,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_CH-1:0]            wr_valid,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]            rd_valid,
  input  logic [NUM_CH-1:0]            rd_read,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH*CNT_W-1:0]      level,
  input  logic [NUM_CH-1:0]            flush,
  output logic [NUM_CH-1:0]            ovf,
  output logic [NUM_CH-1:0]            udf,
  input  logic                         err_clr
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sem_fifo_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .err_clr  (err_clr),
      .wr_data  (wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .wr_valid (wr_valid[c]),
      .full     (full[c]),
      .rd_data  (rd_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid (rd_valid[c]),
      .rd_read  (rd_read[c]),
      .empty    (empty[c]),
      .level    (level[c*CNT_W +: CNT_W]),
      .flush    (flush[c]),
      .ovf      (ovf[c]),
      .udf      (udf[c])
    );
  end

endmodule

`default_nettype wire
